// File: rtl/stop_watch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stop_watch_pkg                                                       |
// | Mode encoding and mode-sequencing helper for the lap stopwatch.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stop_watch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b100,
        CLEAR   = 3'b010,
        RUNNING = 3'b001
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            IDLE:    return CLEAR;
            CLEAR:   return RUNNING;
            default: return IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_sync_edge                                                     |
// | Two-flop synchroniser followed by a single-cycle rising-edge pulse.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module button_sync_edge (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/stop_watch_lap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stop_watch_lap                                                       |
// | Seconds stopwatch with IDLE/CLEAR/RUNNING modes and a lap FIFO.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stop_watch_lap
    import stop_watch_pkg::*;
#(
    parameter int TIME_W        = 5,
    parameter int TICKS_PER_SEC = 100,
    parameter int LAP_DEPTH     = 4,
    parameter int WRAP          = 1
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         button_i,
    input  logic                         lap_i,
    input  logic                         lap_rd_i,
    output logic [2:0]                   state,
    output logic [TIME_W-1:0]            time_o,
    output logic [TIME_W-1:0]            lap_o,
    output logic                         lap_valid_o,
    output logic [$clog2(LAP_DEPTH):0]   lap_count_o,
    output logic                         overflow_o,
    output logic                         lap_drop_o
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [TIME_W-1:0] TIME_MAX  = '1;
    localparam logic [CW-1:0]     FULL_CNT  = CW'(LAP_DEPTH);

    mode_t             state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TIME_W-1:0] mem_q [LAP_DEPTH];

    logic btn_evt;
    logic lap_evt;
    logic full;
    logic push;
    logic pop;
    logic push_ok;
    logic tick;

    button_sync_edge u_btn_sync (
        .clk     (clk),
        .rst_i   (rst_i),
        .btn_i   (button_i),
        .pulse_o (btn_evt)
    );

    button_sync_edge u_lap_sync (
        .clk     (clk),
        .rst_i   (rst_i),
        .btn_i   (lap_i),
        .pulse_o (lap_evt)
    );

    assign lap_valid_o = (count_q != '0);
    assign full        = (count_q == FULL_CNT);
    assign push        = lap_evt & (state_q == RUNNING);
    assign pop         = lap_rd_i & lap_valid_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok     = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (btn_evt) begin
            state_d = next_mode(state_q);
        end
    end

    always_comb begin
        presc_d  = '0;
        time_d   = time_q;
        ovf_d    = ovf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = push & full & ~pop;
        tick     = 1'b0;

        if (state_q == RUNNING) begin
            if (presc_q == PRESC_MAX) begin
                tick = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (tick) begin
            if (time_q != TIME_MAX) begin
                time_d = time_q + TIME_W'(1);
            end else if (WRAP != 0) begin
                time_d = '0;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Keying on the next mode makes time_o read zero throughout CLEAR.
        if (state_d == CLEAR) begin
            presc_d  = '0;
            time_d   = '0;
            ovf_d    = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            presc_q  <= '0;
            time_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            time_q   <= time_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= time_q;
        end
    end

    assign state       = state_q;
    assign time_o      = time_q;
    assign lap_o       = lap_valid_o ? mem_q[rd_ptr_q] : '0;
    assign lap_count_o = count_q;
    assign overflow_o  = ovf_q;
    assign lap_drop_o  = drop_q;

endmodule
`default_nettype wire
